// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the pipelined MIPS core.
// Serves the memory-stage port with a word RAM plus an I/O window holding a
// free-running cycle counter, a transmit FIFO drained over valid/ready, and a
// status register with sticky overflow / bad-address bits (write-1-to-clear).
module mips_dmem_responder #(
  parameter int          MEM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_write,
  input  logic [31:0] alu_out,
  input  logic [31:0] dmem_write_data,
  output logic [31:0] dmem_read_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        err
);

  localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [4:0]  DEPTH_C   = 5'(FIFO_DEPTH);

  logic [31:0]           ram_mem [MEM_WORDS];
  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [4:0]            count_reg;
  logic [4:0]            count_next;
  logic [31:0]           cycle_reg;
  logic                  overflow_reg;
  logic                  bad_addr_reg;
  logic [FIFO_DEPTH-1:0] fifo_we;

  // Address decode; misalignment outranks every region, RAM outranks MMIO.
  logic          misaligned;
  logic          is_ram;
  logic          is_cycle;
  logic          is_tx;
  logic          is_status;
  logic          is_unmapped;
  logic [AW-1:0] ram_idx;

  assign misaligned  = (alu_out[1:0] != 2'b00);
  assign is_ram      = !misaligned && (alu_out < RAM_BYTES);
  assign is_cycle    = !misaligned && !is_ram && (alu_out == MMIO_BASE);
  assign is_tx       = !misaligned && !is_ram && (alu_out == MMIO_BASE + 32'h4);
  assign is_status   = !misaligned && !is_ram && (alu_out == MMIO_BASE + 32'h8);
  assign is_unmapped = !misaligned && !is_ram && !is_cycle && !is_tx && !is_status;
  assign ram_idx     = alu_out[AW+1:2];

  // FIFO handshake; a pop frees a slot in the same cycle, so a push into a
  // full FIFO that is also draining is accepted rather than counted as overflow.
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic push_ok;
  logic overflow_set;
  logic overflow_clr;
  logic bad_addr_set;
  logic bad_addr_clr;

  assign fifo_empty   = (count_reg == 5'd0);
  assign fifo_full    = (count_reg == DEPTH_C);
  assign push         = dmem_write && is_tx;
  assign pop          = !fifo_empty && out_ready;
  assign push_ok      = push && (!fifo_full || pop);
  assign overflow_set = push && fifo_full && !pop;
  assign overflow_clr = dmem_write && is_status && dmem_write_data[16];
  assign bad_addr_set = dmem_write && (misaligned || is_unmapped);
  assign bad_addr_clr = dmem_write && is_status && dmem_write_data[17];

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_mem[rd_ptr_reg];
  assign err       = overflow_reg || bad_addr_reg;

  // One write-enable per FIFO slot, selected by the write pointer.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_we
      assign fifo_we[gi] = push_ok && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + 5'd1;
    end else if (!push_ok && pop) begin
      count_next = count_reg - 5'd1;
    end
  end

  // Zero-latency load mux; reads never touch state.
  always_comb begin
    dmem_read_data = 32'h0;
    if (is_ram) begin
      dmem_read_data = ram_mem[ram_idx];
    end else if (is_cycle) begin
      dmem_read_data = cycle_reg;
    end else if (is_status) begin
      dmem_read_data = {14'b0, bad_addr_reg, overflow_reg, 6'b0,
                        fifo_full, fifo_empty, 3'b0, count_reg};
    end
  end

  // RAM storage; contents survive reset but writes under reset are dropped.
  always_ff @(posedge clk) begin
    if (!reset && dmem_write && is_ram) begin
      ram_mem[ram_idx] <= dmem_write_data;
    end
  end

  // FIFO payload storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (!reset && fifo_we[i]) begin
        fifo_mem[i] <= dmem_write_data;
      end
    end
  end

  // Control state: counter, FIFO pointers/count, sticky bits (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_reg    <= 32'h0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= 5'd0;
      overflow_reg <= 1'b0;
      bad_addr_reg <= 1'b0;
    end else begin
      cycle_reg    <= (dmem_write && is_cycle) ? 32'h0 : cycle_reg + 32'h1;
      count_reg    <= count_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      overflow_reg <= (overflow_reg && !overflow_clr) || overflow_set;
      bad_addr_reg <= (bad_addr_reg && !bad_addr_clr) || bad_addr_set;
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Randomized and directed bench for mips_dmem_responder against a
// queue/array reference model of the memory map.
module tb_mips_dmem_responder;

  localparam int          MEM_WORDS  = 64;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] BASE       = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dmem_write = 1'b0;
  logic [31:0] alu_out = 32'h0;
  logic [31:0] dmem_write_data = 32'h0;
  logic [31:0] dmem_read_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        err;

  mips_dmem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MMIO_BASE(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dmem_write(dmem_write),
    .alu_out(alu_out),
    .dmem_write_data(dmem_write_data),
    .dmem_read_data(dmem_read_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_ram [MEM_WORDS];
  bit          m_known [MEM_WORDS];
  logic [31:0] m_cycle;
  logic [31:0] m_q [$];
  bit          m_ovf;
  bit          m_bad;

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 misaligned, 1 RAM, 2 CYCLE, 3 TXDATA, 4 STATUS, 5 unmapped
  function automatic int kind_of(logic [31:0] a);
    if (a[1:0] != 2'b00) return 0;
    if (a < 32'(MEM_WORDS * 4)) return 1;
    if (a == BASE) return 2;
    if (a == BASE + 32'h4) return 3;
    if (a == BASE + 32'h8) return 4;
    return 5;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'h0;
    s[4:0] = 5'(m_q.size());
    s[8]   = (m_q.size() == 0);
    s[9]   = (m_q.size() == FIFO_DEPTH);
    s[16]  = m_ovf;
    s[17]  = m_bad;
    return s;
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    int  k;
    bit  full;
    bit  do_pop;
    if (reset) begin
      m_cycle = 32'h0;
      m_q.delete();
      m_ovf = 1'b0;
      m_bad = 1'b0;
      return;
    end
    k      = kind_of(alu_out);
    full   = (m_q.size() == FIFO_DEPTH);
    do_pop = (m_q.size() != 0) && out_ready;
    m_cycle = (dmem_write && k == 2) ? 32'h0 : m_cycle + 32'h1;
    if (do_pop) void'(m_q.pop_front());
    if (dmem_write) begin
      case (k)
        1: begin
          m_ram[int'(alu_out >> 2)]   = dmem_write_data;
          m_known[int'(alu_out >> 2)] = 1'b1;
        end
        3: begin
          if (!full || do_pop) m_q.push_back(dmem_write_data);
          else m_ovf = 1'b1;
        end
        4: begin
          if (dmem_write_data[16]) m_ovf = 1'b0;
          if (dmem_write_data[17]) m_bad = 1'b0;
        end
        2: ;
        default: m_bad = 1'b1;
      endcase
    end
  endtask

  // Check outputs mid-cycle, then let one edge happen and update the model.
  task automatic cycle(string tag);
    int          k;
    bit          known;
    logic [31:0] exp;
    @(negedge clk);
    k = kind_of(alu_out);
    known = 1'b1;
    exp = 32'h0;
    case (k)
      1: begin
        known = m_known[int'(alu_out >> 2)];
        exp   = m_ram[int'(alu_out >> 2)];
      end
      2: exp = m_cycle;
      4: exp = model_status();
      default: exp = 32'h0;
    endcase
    if (known) check_val({tag, ":rdata"}, dmem_read_data, exp);
    check_val({tag, ":valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check_val({tag, ":odata"}, out_data, m_q[0]);
    check_val({tag, ":err"}, 32'(err), 32'(m_ovf | m_bad));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(bit we, logic [31:0] a, logic [31:0] d, string tag);
    dmem_write      = we;
    alu_out         = a;
    dmem_write_data = d;
    cycle(tag);
  endtask

  function automatic logic [31:0] rand_addr();
    int kind;
    kind = $urandom_range(0, 5);
    case (kind)
      0: return {24'h0, 6'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
      1: return ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      2: return BASE;
      3: return BASE + 32'h4;
      4: return BASE + 32'h8;
      default: begin
        if ($urandom_range(0, 1) == 0)
          return 32'(MEM_WORDS * 4) + 32'(4 * $urandom_range(0, 100));
        return BASE + 32'(4 * $urandom_range(3, 100));
      end
    endcase
  endfunction

  initial begin
    // Bring up under reset; the model starts from the reset state.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_cycle = 32'h0;
    m_ovf = 1'b0;
    m_bad = 1'b0;
    m_q.delete();
    drive(1'b0, BASE, 32'h0, "rst_cycle");
    drive(1'b0, BASE + 32'h8, 32'h0, "rst_status");
    reset = 1'b0;

    // Cycle counter runs 0,1,2,3,4 after reset release
    for (int i = 0; i < 5; i++) drive(1'b0, BASE, 32'h0, "cyc_run");

    // RAM write / readback
    drive(1'b1, 32'h10, 32'hDEAD_BEEF, "ram_w10");
    drive(1'b0, 32'h0, 32'h0, "ram_idle");
    drive(1'b0, 32'h10, 32'h0, "ram_r10");
    drive(1'b1, 32'h14, 32'h0, "ram_w14");
    drive(1'b0, 32'h14, 32'h0, "ram_r14");

    // Counter clear by write, then wrap from all-ones
    drive(1'b1, BASE, 32'h1234_5678, "cyc_w");
    drive(1'b0, BASE, 32'h0, "cyc_clr");
    dmem_write = 1'b0;
    alu_out = BASE;
    force dut.cycle_reg = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_reg;
    m_cycle = 32'hFFFF_FFFF;
    drive(1'b0, BASE, 32'h0, "cyc_max");
    drive(1'b0, BASE, 32'h0, "cyc_wrap");

    // FIFO fill with out_ready low, then overflow
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) drive(1'b1, BASE + 32'h4, 32'(v), "fifo_push");
    drive(1'b0, BASE + 32'h8, 32'h0, "fifo_full_st");
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b0, BASE + 32'h8, 32'h0, "fifo_drain");
    out_ready = 1'b0;
    drive(1'b1, BASE + 32'h8, 32'h0001_0000, "ovf_clr");

    // Push while full with simultaneous pop
    for (int v = 11; v <= 14; v++) drive(1'b1, BASE + 32'h4, 32'(v), "pp_fill");
    out_ready = 1'b1;
    drive(1'b1, BASE + 32'h4, 32'h9, "pp_push9");
    for (int i = 0; i < 5; i++) drive(1'b0, BASE + 32'h8, 32'h0, "pp_drain");
    out_ready = 1'b0;

    // Bad addresses: misaligned and unmapped
    drive(1'b1, 32'h0000_0102, 32'hAAAA_AAAA, "bad_mis_w");
    drive(1'b1, BASE + 32'hC, 32'hBBBB_BBBB, "bad_unm_w");
    drive(1'b0, 32'h0000_0102, 32'h0, "bad_mis_r");
    drive(1'b0, BASE + 32'hC, 32'h0, "bad_unm_r");
    drive(1'b0, BASE + 32'h8, 32'h0, "bad_st");
    drive(1'b1, BASE + 32'h8, 32'h0002_0000, "bad_clr");
    drive(1'b0, BASE + 32'h8, 32'h0, "bad_clr_st");
    drive(1'b0, 32'h10, 32'h0, "bad_ram_keep");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      out_ready = $urandom_range(0, 1);
      drive(($urandom_range(0, 1) == 1), rand_addr(), $urandom(), "rnd");
    end
    reset = 1'b0;

    // Reset mid-operation: 3 entries queued, overflow set
    out_ready = 1'b1;
    drive(1'b1, BASE + 32'h8, 32'h0003_0000, "mr_clr");
    for (int i = 0; i < 5; i++) drive(1'b0, BASE + 32'h8, 32'h0, "mr_empty");
    out_ready = 1'b0;
    for (int v = 21; v <= 25; v++) drive(1'b1, BASE + 32'h4, 32'(v), "mr_fill");
    out_ready = 1'b1;
    drive(1'b1, 32'h20, 32'h5A5A_5A5A, "mr_pop_ramw");
    out_ready = 1'b0;
    drive(1'b0, BASE + 32'h8, 32'h0, "mr_pre_st");
    reset = 1'b1;
    drive(1'b1, 32'h20, 32'h0BAD_0BAD, "mr_reset");
    reset = 1'b0;
    drive(1'b0, BASE + 32'h8, 32'h0, "mr_post_st");
    drive(1'b0, BASE, 32'h0, "mr_post_cyc");
    drive(1'b0, 32'h20, 32'h0, "mr_post_ram");
    check_val("mr_ram_const", dmem_read_data, 32'h5A5A_5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
